// File: rtl/neuron_pkg.sv
// Shared constants and types for the spike event encoder.
package neuron_pkg;

  localparam int unsigned ISI_W = 16;
  localparam logic [ISI_W-1:0] ISI_MAX = 16'hFFFF;

  localparam int unsigned BYTE_W        = 8;
  // A frame is sent most-significant byte first.
  localparam int unsigned FRAME_HI_BYTE = 1;
  localparam int unsigned FRAME_LO_BYTE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/spike_event_encoder_if.sv
// Valid/ready byte stream carrying serialized ISI frames.
interface spike_event_encoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/spike_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only alongside a pop.
module spike_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  always_comb begin
    level   = r_wr_ptr - r_rd_ptr;
    full    = (level == FULL_LVL);
    empty   = (level == '0);
    w_rd_en = pop && !empty;
    w_wr_en = push && (!full || w_rd_en);
    dout    = r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_event_encoder.sv
// Measures inter-spike intervals in enabled timesteps and streams each as a
// two-byte frame; overload drops are counted and flagged.
module spike_event_encoder
  import neuron_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     spike_in,
  spike_event_encoder_if.master    out_if,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  logic [ISI_W-1:0] r_isi_cnt;
  logic [ISI_W-1:0] w_isi_inc;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [ISI_W-1:0] w_fifo_dout;

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [ISI_W-1:0] r_frame;
  logic [ISI_W-1:0] w_frame_nxt;

  logic             r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  always_comb begin
    w_isi_inc = (r_isi_cnt == ISI_MAX) ? ISI_MAX : r_isi_cnt + 1'b1;
    w_push    = ena && spike_in;
    w_drop    = w_push && w_full && !w_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isi_cnt <= '0;
    end else if (ena) begin
      r_isi_cnt <= spike_in ? '0 : w_isi_inc;
    end
  end

  spike_fifo #(
    .WIDTH (ISI_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_isi_inc),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // Popping directly out of LO lets frames run back-to-back with no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_frame_nxt = w_fifo_dout;
          w_state_nxt = HI;
        end
      end
      HI: begin
        if (out_if.out_ready) w_state_nxt = LO;
      end
      LO: begin
        if (out_if.out_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_frame_nxt = w_fifo_dout;
            w_state_nxt = HI;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_if.out_valid = 1'b0;
    out_if.out_data  = '0;
    out_if.out_last  = 1'b0;
    unique case (r_state)
      HI: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = r_frame[FRAME_HI_BYTE*BYTE_W +: BYTE_W];
      end
      LO: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = r_frame[FRAME_LO_BYTE*BYTE_W +: BYTE_W];
        out_if.out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed self-checking bench for spike_event_encoder (DEPTH=4, DROP_W=8).
module tb_spike_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       spike_in;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_level;

  spike_event_encoder_if bus ();

  spike_event_encoder #(
    .DEPTH  (4),
    .DROP_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spike_in   (spike_in),
    .out_if     (bus.master),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [8:0]  cap_q [$];
  int          cap_cyc [$];

  // Records a byte when the coming edge completes a handshake, then advances one cycle.
  task automatic tick();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      cap_q.push_back({bus.out_last, bus.out_data});
      cap_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    ena = 1'b0; spike_in = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cyc = 0;
    cap_q.delete();
    cap_cyc.delete();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, overflow, drop_cnt, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_init got valid=%b data=%h last=%b ovf=%b drop=%0d lvl=%0d exp all 0",
               bus.out_valid, bus.out_data, bus.out_last, overflow, drop_cnt, fifo_level);
    end
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 14; c++) begin
      spike_in = (c % 2 == 1) && (c <= 11);
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || overflow !== 1'b1 || fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_preload got valid=%b ovf=%b lvl=%0d exp 1 1 4", bus.out_valid, overflow, fifo_level);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, overflow, drop_cnt, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got valid=%b data=%h last=%b ovf=%b drop=%0d lvl=%0d exp all 0",
               bus.out_valid, bus.out_data, bus.out_last, overflow, drop_cnt, fifo_level);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_isi();
    logic [8:0] exp_b [4];
    logic [8:0] got;
    exp_b[0] = 9'h000; exp_b[1] = 9'h106; exp_b[2] = 9'h000; exp_b[3] = 9'h10A;
    do_reset();
    ena = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      spike_in = (c == 5) || (c == 15);
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (cap_q.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count got=%0d exp=4", cap_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_checks++;
      if (got !== exp_b[i]) begin
        n_fail++;
        $display("FAIL basic_byte%0d got=%h exp=%h", i, got, exp_b[i]);
      end
    end
    n_checks++;
    if (cap_cyc.size() == 0 || cap_cyc[0] != 7) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d exp=7", (cap_cyc.size() == 0) ? -1 : cap_cyc[0]);
    end
  endtask

  task automatic test_saturation();
    logic [8:0] exp_b [4];
    logic [8:0] got;
    exp_b[0] = 9'h0FF; exp_b[1] = 9'h1FF; exp_b[2] = 9'h000; exp_b[3] = 9'h103;
    do_reset();
    ena = 1'b1; bus.out_ready = 1'b1;
    repeat (70000) tick();
    spike_in = 1'b1; tick();
    spike_in = 1'b0; tick(); tick();
    spike_in = 1'b1; tick();
    spike_in = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (cap_q.size() != 4) begin
      n_fail++;
      $display("FAIL sat_count got=%0d exp=4", cap_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_checks++;
      if (got !== exp_b[i]) begin
        n_fail++;
        $display("FAIL sat_byte%0d got=%h exp=%h", i, got, exp_b[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [8:0] got;
    logic [8:0] exp_v;
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 14; c++) begin
      spike_in = (c % 2 == 1) && (c <= 11);
      if (c >= 3) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_stall_c%0d got valid=%b data=%h last=%b exp 1 00 0",
                   c, bus.out_valid, bus.out_data, bus.out_last);
        end
      end
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd4 || drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state got lvl=%0d drop=%0d ovf=%b exp 4 1 1", fifo_level, drop_cnt, overflow);
    end
    bus.out_ready = 1'b1;
    repeat (16) tick();
    n_checks++;
    if (cap_q.size() != 10) begin
      n_fail++;
      $display("FAIL ovf_drain_count got=%0d exp=10", cap_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      got   = (i < cap_q.size()) ? cap_q[i] : 'x;
      exp_v = (i % 2 == 0) ? 9'h000 : 9'h102;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL ovf_byte%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 8'd1 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_after got valid=%b ovf=%b drop=%0d lvl=%0d exp 0 1 1 0",
               bus.out_valid, overflow, drop_cnt, fifo_level);
    end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] got;
    logic [8:0] exp_v;
    do_reset();
    ena = 1'b1;
    for (int c = 0; c < 13; c++) begin
      spike_in      = ((c % 2 == 1) && (c <= 9)) || (c == 12);
      bus.out_ready = (c >= 11);
      if (c == 11) begin
        n_checks++;
        if (fifo_level !== 3'd4) begin
          n_fail++;
          $display("FAIL fpp_full got lvl=%0d exp=4", fifo_level);
        end
      end
      if (c == 12) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
          n_fail++;
          $display("FAIL fpp_lo_phase got valid=%b last=%b exp 1 1", bus.out_valid, bus.out_last);
        end
      end
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd4 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fpp_nodrop got lvl=%0d drop=%0d ovf=%b exp 4 0 0", fifo_level, drop_cnt, overflow);
    end
    repeat (16) tick();
    n_checks++;
    if (cap_q.size() != 12) begin
      n_fail++;
      $display("FAIL fpp_count got=%0d exp=12", cap_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      got   = (i < cap_q.size()) ? cap_q[i] : 'x;
      exp_v = (i % 2 == 0) ? 9'h000 : ((i == 11) ? 9'h103 : 9'h102);
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL fpp_byte%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [8:0] exp_b [4];
    logic [8:0] got;
    exp_b[0] = 9'h000; exp_b[1] = 9'h104; exp_b[2] = 9'h000; exp_b[3] = 9'h000;
    do_reset();
    bus.out_ready = 1'b1;
    ena = 1'b0;
    for (int c = 0; c < 20; c++) begin
      spike_in = (c % 2 == 0);
      tick();
    end
    spike_in = 1'b0;
    n_checks++;
    if (cap_q.size() != 0 || bus.out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL gate_idle got bytes=%0d valid=%b lvl=%0d exp 0 0 0", cap_q.size(), bus.out_valid, fifo_level);
    end
    ena = 1'b1;
    for (int c = 0; c < 4; c++) begin
      spike_in = (c == 3);
      tick();
    end
    spike_in = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (cap_q.size() != 2) begin
      n_fail++;
      $display("FAIL gate_count got=%0d exp=2", cap_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 'x;
      n_checks++;
      if (got !== exp_b[i]) begin
        n_fail++;
        $display("FAIL gate_byte%0d got=%h exp=%h", i, got, exp_b[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; spike_in = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_basic_isi();
    test_overflow();
    test_full_push_pop();
    test_enable_gating();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
